// File: rtl/serial_pattern_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package serial_pattern_gen_pkg;

  // Default maximum pattern length and the matching length-port width.
  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_LW = 4;

  // Transmit controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spg_state_t;

  // Limits a requested length to the register width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_shift_reg.sv
// Loadable left-shift register plus bit down-counter for one pattern pass.
// On load the pattern is left-aligned so that pattern[len-1] sits in the
// MSB; a copy of the aligned pattern is kept so repetitions can reload it
// without looking at the (possibly changed) input port again.
module pattern_shift_reg
  import serial_pattern_gen_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,     // capture pattern/len from the ports
  input  logic          i_reload,   // restart the pass from the stored copy
  input  logic          i_shift,    // advance one bit
  input  logic [W-1:0]  i_pattern,
  input  logic [LW-1:0] i_len,      // already clamped to W by the caller
  output logic          o_msb,      // bit currently presented
  output logic          o_last      // presented bit is bit 0 of the pass
);

  logic [W-1:0]  r_sreg;
  logic [W-1:0]  r_pat;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;

  logic [LW-1:0] w_shamt;
  logic [W-1:0]  w_aligned;

  // Left-align the pattern: bits above len-1 fall off the top.
  always_comb begin
    w_shamt   = LW'(W) - i_len;
    w_aligned = i_pattern << w_shamt;
  end

  // Shift register, stored copy, length and remaining-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_pat  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= w_aligned;
      r_pat  <= w_aligned;
      r_len  <= i_len;
      r_cnt  <= i_len - LW'(1);
    end else if (i_reload) begin
      r_sreg <= r_pat;
      r_cnt  <= r_len - LW'(1);
    end else if (i_shift) begin
      r_sreg <= {r_sreg[W-2:0], 1'b0};
      r_cnt  <= r_cnt - LW'(1);
    end
  end

  assign o_msb  = r_sreg[W-1];
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends a latched pattern MSB-first rep+1 times
// back to back, then pulses done for one cycle.
//
// Handshake: start and stop are level requests sampled on the rising edge
// of clk. start is only looked at in IDLE (never queued while busy); stop
// is only looked at in SHIFT, where it makes the bit currently on x the
// last valid one. x carries a pattern bit exactly in the cycles where
// x_valid is high and is held at 0 otherwise; no back-pressure exists.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [3:0]    rep,
  input  logic          stop,
  output logic          x,
  output logic          x_valid,
  output logic          busy,
  output logic          done,
  output spg_state_t    dbg_state
);

  spg_state_t    r_state;
  spg_state_t    w_next;
  logic [3:0]    r_rep_left;

  logic [LW-1:0] w_len_eff;
  logic          w_load;
  logic          w_reload;
  logic          w_shift;
  logic          w_rep_dec;
  logic          w_msb;
  logic          w_last;

  // Effective length L = min(len, W).
  always_comb begin
    w_len_eff = LW'(clamp_len(32'(len), W));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_reload  = 1'b0;
    w_shift   = 1'b0;
    w_rep_dec = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (w_len_eff != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (stop) begin
          w_next = ST_DONE;
        end else if (w_last) begin
          if (r_rep_left != 4'd0) begin
            w_reload  = 1'b1;
            w_rep_dec = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Remaining-repetition counter, captured with the pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_left <= 4'd0;
    end else if (w_load) begin
      r_rep_left <= rep;
    end else if (w_rep_dec) begin
      r_rep_left <= r_rep_left - 4'd1;
    end
  end

  pattern_shift_reg #(
    .W  (W),
    .LW (LW)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst),
    .i_load    (w_load),
    .i_reload  (w_reload),
    .i_shift   (w_shift),
    .i_pattern (pattern),
    .i_len     (w_len_eff),
    .o_msb     (w_msb),
    .o_last    (w_last)
  );

  // Moore outputs decoded from registers only; reset clears them at once.
  always_comb begin
    x_valid   = (r_state == ST_SHIFT);
    x         = (r_state == ST_SHIFT) & w_msb;
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen with a chained 111 Moore detector.
module tb_serial_pattern_gen;
  import serial_pattern_gen_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rep;
  logic       stop;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;
  spg_state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_gen #(.W(8), .LW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .rep       (rep),
    .stop      (stop),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Downstream 111 detector: counts consecutive ones, y in the third state.
  logic [1:0] det_st;
  logic       det_y;
  always @(posedge clk or negedge rst) begin
    if (!rst) det_st <= 2'd0;
    else if (x_valid && x) det_st <= (det_st == 2'd3) ? 2'd3 : det_st + 2'd1;
    else det_st <= 2'd0;
  end
  assign det_y = (det_st == 2'd3);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [63:0] exp_stream;  // valid bits, first sent bit is the MSB
    int          exp_n;
    logic        exp_y;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver ----------------
  // Issues one start at the current negedge and collects the valid stream,
  // then checks the done cycle and the return to IDLE.
  task automatic run_txn(input string tag, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input int stop_at, input bit hold_start,
                         input bit stop_with_start, output int n,
                         output logic [63:0] s, output logic ysn);
    n = 0; s = '0; ysn = 1'b0;
    pattern = p; len = l; rep = r; start = 1'b1; stop = stop_with_start;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    stop = 1'b0;
    for (int cyc = 0; cyc < 100 && x_valid; cyc++) begin
      s = {s[62:0], x};
      n++;
      if (det_y) ysn = 1'b1;
      pattern = 8'($urandom_range(0, 255));
      len     = 4'($urandom_range(0, 15));
      rep     = 4'($urandom_range(0, 15));
      if (n == stop_at) stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    if (det_y) ysn = 1'b1;
    chk({tag, "_timeout"}, 64'(x_valid), 64'd0);
    chk({tag, "_done"},    64'(done), 64'd1);
    chk({tag, "_done_busy"}, 64'(busy), 64'd1);
    chk({tag, "_done_x"},  64'(x), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle"}, {61'd0, busy, done, x_valid}, 64'd0);
  endtask

  // ---------------- test ----------------
  int          n;
  logic [63:0] s;
  logic        ysn;

  initial begin
    vecs[0] = '{8'h07, 4'd3,  4'd1,  64'h3F,   6,  1'b1};
    vecs[1] = '{8'h0B, 4'd4,  4'd0,  64'hB,    4,  1'b0};
    vecs[2] = '{8'hFF, 4'd0,  4'd3,  64'h0,    0,  1'b0};
    vecs[3] = '{8'hA5, 4'd8,  4'd0,  64'hA5,   8,  1'b0};
    vecs[4] = '{8'h81, 4'd12, 4'd0,  64'h81,   8,  1'b0};
    vecs[5] = '{8'hF2, 4'd2,  4'd2,  64'h2A,   6,  1'b0};
    vecs[6] = '{8'h05, 4'd3,  4'd0,  64'h5,    3,  1'b0};
    vecs[7] = '{8'h01, 4'd1,  4'd15, 64'hFFFF, 16, 1'b1};

    rst = 1'b0; start = 1'b0; stop = 1'b0; pattern = '0; len = '0; rep = '0;
    #3;
    chk("rst_outputs", {60'd0, x, x_valid, busy, done}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // stop alone in IDLE does nothing
    stop = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_stop", {61'd0, busy, done, x_valid}, 64'd0);
    stop = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].len, vecs[i].rep,
              -1, 1'b0, 1'b0, n, s, ysn);
      chk($sformatf("vec%0d_count", i), 64'(n), 64'(vecs[i].exp_n));
      chk($sformatf("vec%0d_bits", i), s, vecs[i].exp_stream);
      chk($sformatf("vec%0d_det_y", i), 64'(ysn), 64'(vecs[i].exp_y));
    end

    // abort on the 5th valid bit
    run_txn("abort", 8'hFF, 4'd8, 4'd3, 5, 1'b0, 1'b0, n, s, ysn);
    chk("abort_count", 64'(n), 64'd5);
    chk("abort_bits", s, 64'h1F);

    // start and stop together in IDLE: start wins
    run_txn("startstop", 8'h0B, 4'd4, 4'd0, -1, 1'b0, 1'b1, n, s, ysn);
    chk("startstop_count", 64'(n), 64'd4);
    chk("startstop_bits", s, 64'hB);

    // start held through the whole transmission is not queued
    run_txn("hold", 8'h0B, 4'd4, 4'd0, -1, 1'b1, 1'b0, n, s, ysn);
    chk("hold_count", 64'(n), 64'd4);
    chk("hold_bits", s, 64'hB);
    @(negedge clk);
    chk("hold_stay_idle", {61'd0, busy, done, x_valid}, 64'd0);

    // reset in the middle of SHIFT
    pattern = 8'hFF; len = 4'd8; rep = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_valid", 64'(x_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_outputs", {60'd0, x, x_valid, busy, done}, 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_nodone%0d", k), {62'd0, done, busy}, 64'd0);
    end
    rst = 1'b1;
    run_txn("post_rst", 8'h0B, 4'd4, 4'd0, -1, 1'b0, 1'b0, n, s, ysn);
    chk("post_rst_count", 64'(n), 64'd4);
    chk("post_rst_bits", s, 64'hB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
